// File: rtl/floo_narrow_wide_pkg.sv
// Shared types and constants for the multicast response reduction path.
package floo_narrow_wide_pkg;

  localparam int unsigned NumMcastBits = 4;
  localparam int unsigned SamNumRules  = 4;
  localparam int unsigned IdW          = 2;

  typedef struct packed {
    logic [IdW-1:0] x;
    logic [IdW-1:0] y;
  } id_t;

  typedef logic [NumMcastBits-1:0] select_t;

  typedef enum logic [2:0] {
    Eject = 3'd0,
    North = 3'd1,
    East  = 3'd2,
    South = 3'd3,
    West  = 3'd4
  } route_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StSend    = 2'd2
  } rsp_state_e;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespExOkay = 2'd1;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  // Destination coordinates addressed by each multicast mask bit.
  localparam id_t McastDstLut [NumMcastBits] = '{
    '{x: 2'd0, y: 2'd1},
    '{x: 2'd1, y: 2'd0},
    '{x: 2'd2, y: 2'd1},
    '{x: 2'd1, y: 2'd2}
  };

endpackage

// File: rtl/mcast_exp_routes.sv
// Maps a multicast destination mask to the set of output routes it fans out on
// under XY routing; shared by the request fork and the response reducer.
module mcast_exp_routes
  import floo_narrow_wide_pkg::*;
#(
  parameter int unsigned NumRoutes = 5
) (
  input  select_t              mask_i,
  input  id_t                  xy_id_i,
  input  id_t                  src_id_i,
  output logic [NumRoutes-1:0] exp_o
);

  always_comb begin
    exp_o = '0;
    for (int unsigned i = 0; i < NumMcastBits; i++) begin
      // The source never waits on a response from itself.
      if (mask_i[i] && (McastDstLut[i] != src_id_i)) begin
        if (McastDstLut[i] == xy_id_i) begin
          exp_o[Eject] = 1'b1;
        end else if (McastDstLut[i].x == xy_id_i.x) begin
          if (McastDstLut[i].y < xy_id_i.y) exp_o[South] = 1'b1;
          else                              exp_o[North] = 1'b1;
        end else begin
          if (McastDstLut[i].x < xy_id_i.x) exp_o[West] = 1'b1;
          else                              exp_o[East] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mcast_rsp_reduce.sv
// Collects one response per expected multicast route and returns the single
// worst-case response code toward the request source.
//
//   state     | meaning
//   StIdle    | ready to be armed with a new multicast request
//   StCollect | waiting for responses on the remaining expected routes
//   StSend    | merged response presented until downstream accepts it
module mcast_rsp_reduce
  import floo_narrow_wide_pkg::*;
#(
  parameter int unsigned NumRoutes = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_valid_i,
  output logic                      start_ready_o,
  input  select_t                   mask_i,
  input  id_t                       xy_id_i,
  input  id_t                       src_id_i,
  input  logic [NumRoutes-1:0]      rsp_valid_i,
  output logic [NumRoutes-1:0]      rsp_ready_o,
  input  logic [NumRoutes-1:0][1:0] rsp_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [1:0]                out_rsp_o,
  output logic                      busy_o,
  output logic                      unexp_o
);

  rsp_state_e           state_d, state_q;
  logic [NumRoutes-1:0] exp_d, exp_q;
  logic [NumRoutes-1:0] arr_d, arr_q;
  logic [1:0]           acc_d, acc_q;
  logic [NumRoutes-1:0] exp_calc;
  logic [NumRoutes-1:0] pend;
  logic [NumRoutes-1:0] accept;

  mcast_exp_routes #(
    .NumRoutes (NumRoutes)
  ) i_exp_routes (
    .mask_i   (mask_i),
    .xy_id_i  (xy_id_i),
    .src_id_i (src_id_i),
    .exp_o    (exp_calc)
  );

  always_comb begin
    pend    = (state_q == StCollect) ? (exp_q & ~arr_q) : '0;
    accept  = rsp_valid_i & pend;

    // Handshake outputs depend only on registered state; reset masks them.
    rsp_ready_o   = rst_i ? '0 : pend;
    start_ready_o = ~rst_i & (state_q == StIdle);
    out_valid_o   = ~rst_i & (state_q == StSend);
    busy_o        = ~rst_i & (state_q != StIdle);
    unexp_o       = ~rst_i & (|(rsp_valid_i & ~pend));
    out_rsp_o     = acc_q;

    state_d = state_q;
    exp_d   = exp_q;
    arr_d   = arr_q;
    acc_d   = acc_q;

    unique case (state_q)
      StIdle: begin
        if (start_valid_i) begin
          exp_d   = exp_calc;
          arr_d   = '0;
          acc_d   = RespOkay;
          state_d = (exp_calc == '0) ? StSend : StCollect;
        end
      end
      StCollect: begin
        arr_d = arr_q | accept;
        // Resp codes are ordered by severity, so the merge is a plain max.
        for (int unsigned r = 0; r < NumRoutes; r++) begin
          if (accept[r] && (rsp_i[r] > acc_d)) acc_d = rsp_i[r];
        end
        if (arr_d == exp_q) state_d = StSend;
      end
      StSend: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      exp_q   <= '0;
      arr_q   <= '0;
      acc_q   <= RespOkay;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      arr_q   <= arr_d;
      acc_q   <= acc_d;
    end
  end

endmodule
